// File: rtl/alu_md_unit.sv
// -----------------------------------------------------------------------------
// alu_md_unit
//
// Execute-stage ALU control decoder with an attached iterative multiply/divide
// sequencer for the pipelined MIPS CPU.
//
//   * Decodes ALUOp/Funct into the 4-bit ALUControl for the main ALU.
//   * Runs mult/multu (and div/divu when enabled) over WIDTH iterate cycles
//     plus one sign-fix cycle, into private HI/LO registers.
//   * Serves mfhi/mflo (through MDSel/MDResult) and mthi/mtlo (write SrcA).
//   * Raises Stall while an HI/LO-dependent instruction sits in EX and the
//     sequencer is busy. Non-MD instructions keep flowing.
//
// Configuration macro:
//   ALU_DIV_EN  defined   : div/divu are executed by a restoring divider.
//               undefined : div/divu are no-ops (no Busy, no Stall, HI/LO kept).
//
// Ports:
//   clk         in   pipeline clock, all state updates on the rising edge
//   reset       in   synchronous, active-high, clears all state
//   Valid       in   EX-stage instruction is real (not a bubble)
//   ALUOp[1:0]  in   00 add, 01 sub, 10 R-type (use Funct), 11 or
//   Funct[5:0]  in   instruction[5:0]
//   SrcA        in   rs operand (WIDTH bits)
//   SrcB        in   rt operand (WIDTH bits)
//   ALUControl  out  main-ALU operation (combinational)
//   MDSel       out  EX result comes from MDResult (mfhi/mflo)
//   MDResult    out  HI for mfhi, LO for mflo, else 0
//   Busy        out  sequencer iterating (registered)
//   Stall       out  hold IF/ID/EX, bubble MEM (combinational)
// -----------------------------------------------------------------------------
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [3:0]       ALUControl,
    output logic             MDSel,
    output logic [WIDTH-1:0] MDResult,
    output logic             Busy,
    output logic             Stall
);

    // R-type function codes handled by the main ALU
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // R-type function codes handled by the multiply/divide unit
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef ALU_DIV_EN
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
`endif
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

`ifdef ALU_DIV_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd3
    } md_state_t;
`endif

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   acc;     // product high half / partial remainder
    logic [WIDTH-1:0]   qr;      // multiplier->product low half / dividend->quotient
    logic [WIDTH-1:0]   m;       // multiplicand / divisor (magnitude)
    logic               neg_q;   // negate product or quotient in FIX
`ifdef ALU_DIV_EN
    logic               neg_r;   // negate remainder in FIX (dividend sign)
    logic               is_div;  // FIX unpacks quotient/remainder, not product
`endif

    // -------------------------------------------------------------------------
    // Instruction decode
    // -------------------------------------------------------------------------
    logic is_r;
    logic op_mult, op_multu, op_mfhi, op_mthi, op_mflo, op_mtlo;
    logic op_signed, op_muls, md_any, issue;
`ifdef ALU_DIV_EN
    logic op_div, op_divu, op_divs;
`endif

    assign is_r     = (ALUOp == 2'b10);
    assign op_mult  = is_r && (Funct == F_MULT);
    assign op_multu = is_r && (Funct == F_MULTU);
    assign op_mfhi  = is_r && (Funct == F_MFHI);
    assign op_mthi  = is_r && (Funct == F_MTHI);
    assign op_mflo  = is_r && (Funct == F_MFLO);
    assign op_mtlo  = is_r && (Funct == F_MTLO);
    assign op_muls  = op_mult || op_multu;

`ifdef ALU_DIV_EN
    assign op_div    = is_r && (Funct == F_DIV);
    assign op_divu   = is_r && (Funct == F_DIVU);
    assign op_divs   = op_div || op_divu;
    assign op_signed = op_mult || op_div;
    assign md_any    = op_muls || op_divs || op_mfhi || op_mthi || op_mflo || op_mtlo;
`else
    // div/divu are not MD ops in this build: they never stall or touch HI/LO.
    assign op_signed = op_mult;
    assign md_any    = op_muls || op_mfhi || op_mthi || op_mflo || op_mtlo;
`endif

    // Busy is only ever set by an issue from IDLE, so every MD op that gets
    // past Stall sees the sequencer idle.
    assign Stall = Valid && Busy && md_any;
    assign issue = Valid && !Stall;

    assign MDSel    = op_mfhi || op_mflo;
    assign MDResult = op_mfhi ? hi : (op_mflo ? lo : '0);

    always_comb begin
        // NOTE: every output of a combinational block gets a default up front;
        // a path through the case that forgets to assign would infer a latch.
        ALUControl = 4'b0000;
        case (ALUOp)
            2'b00: ALUControl = 4'b0010;
            2'b01: ALUControl = 4'b0110;
            2'b11: ALUControl = 4'b0001;
            default: begin
                case (Funct)
                    F_ADD:   ALUControl = 4'b0010;
                    F_SUB:   ALUControl = 4'b0110;
                    F_AND:   ALUControl = 4'b0000;
                    F_OR:    ALUControl = 4'b0001;
                    F_XOR:   ALUControl = 4'b1101;
                    F_NOR:   ALUControl = 4'b1100;
                    F_SLT:   ALUControl = 4'b0111;
                    F_SLTU:  ALUControl = 4'b1111;
                    default: ALUControl = 4'b0000;
                endcase
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath helpers
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;

    // Signed ops iterate on magnitudes; the sign is restored in FIX.
    assign abs_a = (op_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign abs_b = (op_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    // Shift-add: add the multiplicand when the current multiplier LSB is set,
    // then shift {acc,qr} right by one, dropping the consumed multiplier bit.
    assign mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    assign prod_raw = {acc, qr};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;

    // Restoring step: bring the next dividend bit into the partial remainder
    // and subtract the divisor; a borrow (MSB set) means restore.
    // With a zero divisor the subtract never borrows, giving an all-ones
    // quotient and the dividend as remainder with no special case.
    assign div_shift = {acc, qr[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, m};
`endif

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register sees the pre-edge values of the others regardless of order.
        if (reset) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            acc   <= '0;
            qr    <= '0;
            m     <= '0;
            neg_q <= 1'b0;
`ifdef ALU_DIV_EN
            neg_r  <= 1'b0;
            is_div <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (issue) begin
                        if (op_mthi) hi <= SrcA;
                        if (op_mtlo) lo <= SrcA;
                        if (op_muls) begin
                            acc   <= '0;
                            qr    <= abs_b;
                            m     <= abs_a;
                            neg_q <= op_mult && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                            cnt   <= CNT_W'(WIDTH);
                            state <= S_MUL;
                            Busy  <= 1'b1;
`ifdef ALU_DIV_EN
                            is_div <= 1'b0;
`endif
                        end
`ifdef ALU_DIV_EN
                        if (op_divs) begin
                            acc    <= '0;
                            qr     <= abs_a;
                            m      <= abs_b;
                            neg_q  <= op_div && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                            neg_r  <= op_div && SrcA[WIDTH-1];
                            is_div <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            state  <= S_DIV;
                            Busy   <= 1'b1;
                        end
`endif
                    end
                end

                S_MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    qr  <= {mul_sum[0], qr[WIDTH-1:1]};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end

`ifdef ALU_DIV_EN
                S_DIV: begin
                    if (!div_diff[WIDTH+1]) begin
                        acc <= div_diff[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= div_shift[WIDTH-1:0];
                        qr  <= {qr[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= S_FIX;
                end
`endif

                S_FIX: begin
`ifdef ALU_DIV_EN
                    if (is_div) begin
                        lo <= neg_q ? -qr  : qr;
                        hi <= neg_r ? -acc : acc;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
`else
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
`endif
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_md_unit
//
// Directed testbench for alu_md_unit (WIDTH=32). Inputs are driven just after
// the falling edge and outputs are sampled 1 time unit later, away from the
// rising edge where state changes. Division expectations follow ALU_DIV_EN.
// -----------------------------------------------------------------------------
module tb_alu_md_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    logic         clk;
    logic         reset;
    logic         Valid;
    logic [1:0]   ALUOp;
    logic [5:0]   Funct;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic [3:0]   ALUControl;
    logic         MDSel;
    logic [W-1:0] MDResult;
    logic         Busy;
    logic         Stall;

    int checks   = 0;
    int failures = 0;

    alu_md_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Valid      (Valid),
        .ALUOp      (ALUOp),
        .Funct      (Funct),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .MDSel      (MDSel),
        .MDResult   (MDResult),
        .Busy       (Busy),
        .Stall      (Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        Valid = v;
        ALUOp = op;
        Funct = f;
        SrcA  = a;
        SrcB  = b;
    endtask

    // Read HI and LO through mfhi/mflo in the current (idle) cycle.
    task automatic read_hilo(input string tag, input logic [W-1:0] exp_hi,
                             input logic [W-1:0] exp_lo);
        drive(1'b1, 2'b10, F_MFHI, '0, '0);
        #1;
        check({tag, "_hi"}, MDResult, exp_hi);
        check({tag, "_hi_stall"}, Stall, 1'b0);
        drive(1'b1, 2'b10, F_MFLO, '0, '0);
        #1;
        check({tag, "_lo"}, MDResult, exp_lo);
    endtask

    // Advance cycle by cycle (inputs held) while Busy is high; bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        #1;
    endtask

    logic [11:0] dec_vec [14];
    int n;

    initial begin
        dec_vec = '{
            {2'b00, 6'b000000, 4'b0010},
            {2'b01, 6'b000000, 4'b0110},
            {2'b11, 6'b000000, 4'b0001},
            {2'b10, 6'b100000, 4'b0010},
            {2'b10, 6'b100010, 4'b0110},
            {2'b10, 6'b100100, 4'b0000},
            {2'b10, 6'b100101, 4'b0001},
            {2'b10, 6'b100110, 4'b1101},
            {2'b10, 6'b100111, 4'b1100},
            {2'b10, 6'b101010, 4'b0111},
            {2'b10, 6'b101011, 4'b1111},
            {2'b10, 6'b011000, 4'b0000},
            {2'b10, 6'b010000, 4'b0000},
            {2'b10, 6'b111111, 4'b0000}
        };

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive(1'b0, 2'b00, 6'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", Busy, 1'b0);
        read_hilo("rst", 32'h0, 32'h0);
        check("rst_mdsel", MDSel, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- decode sweep (Valid=0 so nothing issues) ----------------
        foreach (dec_vec[i]) begin
            drive(1'b0, dec_vec[i][11:10], dec_vec[i][9:4], '0, '0);
            #1;
            check($sformatf("dec_%0d", i), ALUControl, dec_vec[i][3:0]);
        end
        check("dec_ff_mdsel", MDSel, 1'b0);
        check("dec_ff_mdres", MDResult, 32'h0);
        check("dec_novalid_busy", Busy, 1'b0);

        // ---------------- mult -2*3, then mflo the next cycle ----------------
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULT, 32'hFFFF_FFFE, 32'h3);
        #1;
        check("mult_issue_stall", Stall, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFLO, '0, '0);
        #1;
        check("mflo_stall_first", Stall, 1'b1);
        n = 0;
        while (Stall && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("mflo_stall_cycles", n, 33);
        check("mflo_busy_done", Busy, 1'b0);
        check("mflo_mdsel", MDSel, 1'b1);
        check("mflo_lo", MDResult, 32'hFFFF_FFFA);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // ---------------- multu with overlapping non-MD traffic ----------------
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULTU, 32'hFFFF_FFFE, 32'h3);
        @(negedge clk);
        drive(1'b1, 2'b00, 6'b0, 32'h1, 32'h2);          // add during Busy
        #1;
        check("add_busy", Busy, 1'b1);
        check("add_stall", Stall, 1'b0);
        check("add_aluctl", ALUControl, 4'b0010);
        @(negedge clk);
        drive(1'b0, 2'b10, F_MFHI, '0, '0);              // bubble MD op
        #1;
        check("novalid_stall", Stall, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFHI, '0, '0);
        #1;
        check("mfhi_busy_stall", Stall, 1'b1);
        wait_idle(n);
        check("multu_busy_cycles", n + 2, 33);
        check("multu_mfhi", MDResult, 32'h0000_0002);
        check("multu_mfhi_stall", Stall, 1'b0);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        // ---------------- divide ----------------
`ifdef ALU_DIV_EN
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIV, 32'hFFFF_FFF9, 32'h2);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'b0, '0, '0);
        #1;
        wait_idle(n);
        check("div_busy_cycles", n, 33);
        read_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIVU, 32'h7, 32'h0);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'b0, '0, '0);
        #1;
        wait_idle(n);
        check("divu0_busy_cycles", n, 33);
        read_hilo("divu0", 32'h0000_0007, 32'hFFFF_FFFF);
`else
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIV, 32'hFFFF_FFF9, 32'h2);
        #1;
        check("div_off_stall", Stall, 1'b0);
        check("div_off_aluctl", ALUControl, 4'b0000);
        @(negedge clk);
        drive(1'b1, 2'b10, F_DIVU, 32'h7, 32'h0);
        #1;
        check("div_off_busy", Busy, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'b0, '0, '0);
        #1;
        check("divu_off_busy", Busy, 1'b0);
        read_hilo("div_off", 32'h0000_0002, 32'hFFFF_FFFA);
`endif

        // ---------------- mthi/mtlo then immediate reads ----------------
        @(negedge clk);
        drive(1'b1, 2'b10, F_MTHI, 32'h1234_5678, '0);
        #1;
        check("mthi_stall", Stall, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MFHI, '0, '0);
        #1;
        check("mfhi_after_mthi", MDResult, 32'h1234_5678);
        check("mfhi_after_mthi_stall", Stall, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'b10, F_MTLO, 32'hA5A5_0F0F, '0);
        @(negedge clk);
        read_hilo("mtlo", 32'h1234_5678, 32'hA5A5_0F0F);

        // ---------------- reset in the middle of a mult ----------------
        @(negedge clk);
        drive(1'b1, 2'b10, F_MULT, 32'h5, 32'h7);
        @(negedge clk);
        drive(1'b0, 2'b00, 6'b0, '0, '0);
        repeat (9) @(negedge clk);
        #1;
        check("pre_reset_busy", Busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_reset_busy", Busy, 1'b0);
        read_hilo("post_reset", 32'h0, 32'h0);
        @(negedge clk);
        #1;
        check("post_reset_idle", Busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
